// File: rtl/ui_pkg.sv
// ui_pkg: shared codes for the telephone user interface.
//   - FSM state codes (current_state)
//   - menu item codes (current_menu_item)
//   - outbound command codes and inbound event codes
//   - internal one-hot-free action codes after arbitration
//   - helpers giving each state's menu item range for up/down navigation
package ui_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP  = 3'd0,
    ST_IDLE     = 3'd1,
    ST_MENU     = 3'd2,
    ST_INCOMING = 3'd3,
    ST_BUSY     = 3'd4,
    ST_WAIT_END = 3'd5,
    ST_DIALING  = 3'd6,
    ST_ILLEGAL  = 3'd7
  } state_e;

  localparam logic [5:0] IT_WELCOME     = 6'd0;
  localparam logic [5:0] IT_CALL_NUMBER = 6'd1;
  localparam logic [5:0] IT_STATUS      = 6'd2;
  localparam logic [5:0] IT_CALLER_ID   = 6'd8;
  localparam logic [5:0] IT_ACCEPT      = 6'd9;
  localparam logic [5:0] IT_REJECT      = 6'd10;
  localparam logic [5:0] IT_BUSY_CALLER = 6'd16;
  localparam logic [5:0] IT_END_CALL    = 6'd17;
  localparam logic [5:0] IT_WAIT_END    = 6'd18;
  localparam logic [5:0] IT_ENTER_ADDR  = 6'd24;
  localparam logic [5:0] IT_CALLING     = 6'd25;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_DIAL   = 3'd1;
  localparam logic [2:0] CMD_ACCEPT = 3'd2;
  localparam logic [2:0] CMD_REJECT = 3'd3;
  localparam logic [2:0] CMD_END    = 3'd4;

  localparam logic [2:0] EV_CONNECTED = 3'd1;
  localparam logic [2:0] EV_FAILED    = 3'd2;
  localparam logic [2:0] EV_INCOMING  = 3'd5;
  localparam logic [2:0] EV_ENDED     = 3'd6;

  // Bit positions of the buttons in the internal button vector.
  localparam int BTN_ENTER = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_B0    = 5;
  localparam int BTN_B1    = 6;
  localparam int NUM_BTN   = 7;

  // The single winner of event/button arbitration in a cycle.
  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_ENTER,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_B0,
    ACT_B1,
    ACT_EV_CONNECTED,
    ACT_EV_FAILED,
    ACT_EV_INCOMING,
    ACT_EV_ENDED
  } action_e;

  function automatic logic [5:0] item_lo(input state_e st);
    case (st)
      ST_MENU:     item_lo = IT_CALL_NUMBER;
      ST_INCOMING: item_lo = IT_CALLER_ID;
      ST_BUSY:     item_lo = IT_BUSY_CALLER;
      ST_WAIT_END: item_lo = IT_WAIT_END;
      ST_DIALING:  item_lo = IT_ENTER_ADDR;
      default:     item_lo = IT_WELCOME;
    endcase
  endfunction

  function automatic logic [5:0] item_hi(input state_e st);
    case (st)
      ST_MENU:     item_hi = IT_STATUS;
      ST_INCOMING: item_hi = IT_REJECT;
      ST_BUSY:     item_hi = IT_END_CALL;
      ST_WAIT_END: item_hi = IT_WAIT_END;
      ST_DIALING:  item_hi = IT_CALLING;
      default:     item_hi = IT_WELCOME;
    endcase
  endfunction

endpackage

// File: rtl/ui_edge_detect.sv
// ui_edge_detect: registered change detector.
//   clk, reset : clock and asynchronous active-high reset (history clears to 0)
//   sig_i [W]  : sampled level
//   evt_o      : high while sig_i differs from last cycle's value and is nonzero.
// With W=1 this is a plain rising-edge detector; with W>1 it flags a new
// nonzero code on a level-held bus.
module ui_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sig_i,
  output logic         evt_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= sig_i;
  end

  assign evt_o = (sig_i != prev_q) && (sig_i != '0);

endmodule

// File: rtl/user_interface.sv
// user_interface: menu / call-control FSM of the FPGA telephone.
//   clk, reset           : clock, asynchronous active-high reset
//   s7..s0               : switches, {s7..s0} is the dial address
//   b3..b0               : aux buttons (b0 quick-accept, b1 quick-hangup, b3/b2 unused)
//   enter/up/down/left/right : navigation buttons (debounced, active-high)
//   inc_command [3]      : event code from the application layer (level)
//   init                 : application layer ready
//   inc_address [8]      : caller address for an incoming call
//   address [8]          : peer address (registered)
//   command [3]          : one-cycle command pulse (registered)
//   current_state [3]    : FSM state code
//   current_menu_item [6]: menu item code
// Build option: define UI_QUICK_KEYS_EN to let b0/b1 accept, reject and
// hang up directly; otherwise b0/b1 are ignored.
module user_interface
  import ui_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s7,
  input  logic       s6,
  input  logic       s5,
  input  logic       s4,
  input  logic       s3,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  input  logic       b3,
  input  logic       b2,
  input  logic       b1,
  input  logic       b0,
  input  logic       enter,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [2:0] inc_command,
  input  logic       init,
  input  logic [7:0] inc_address,
  output logic [7:0] address,
  output logic [2:0] command,
  output logic [2:0] current_state,
  output logic [5:0] current_menu_item
);

  logic [7:0]         sw;
  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] btn_rise;
  logic               ev_fire;
  action_e            act;

  state_e     state_q, state_d;
  logic [5:0] item_q,  item_d;
  logic [7:0] addr_q,  addr_d;
  logic [2:0] cmd_q,   cmd_d;

  assign sw  = {s7, s6, s5, s4, s3, s2, s1, s0};
  assign btn = {b1, b0, right, left, down, up, enter};

  // b3/b2 have no function; b0/b1 edges are only consumed with quick keys.
  logic unused_inputs;
  assign unused_inputs = ^{b3, b2, btn_rise[BTN_B1:BTN_B0]};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    ui_edge_detect #(.W(1)) u_btn (
      .clk   (clk),
      .reset (reset),
      .sig_i (btn[g]),
      .evt_o (btn_rise[g])
    );
  end

  ui_edge_detect #(.W(3)) u_ev (
    .clk   (clk),
    .reset (reset),
    .sig_i (inc_command),
    .evt_o (ev_fire)
  );

  // Arbitration: a recognised event beats every button; among buttons the
  // highest-priority rising edge wins and the rest are dropped.
  always_comb begin
    act = ACT_NONE;
    if (ev_fire) begin
      case (inc_command)
        EV_CONNECTED: act = ACT_EV_CONNECTED;
        EV_FAILED:    act = ACT_EV_FAILED;
        EV_INCOMING:  act = ACT_EV_INCOMING;
        EV_ENDED:     act = ACT_EV_ENDED;
        default:      act = ACT_NONE;
      endcase
    end
    if (act == ACT_NONE) begin
      if      (btn_rise[BTN_ENTER]) act = ACT_ENTER;
      else if (btn_rise[BTN_UP])    act = ACT_UP;
      else if (btn_rise[BTN_DOWN])  act = ACT_DOWN;
      else if (btn_rise[BTN_LEFT])  act = ACT_LEFT;
      else if (btn_rise[BTN_RIGHT]) act = ACT_RIGHT;
`ifdef UI_QUICK_KEYS_EN
      else if (btn_rise[BTN_B0])    act = ACT_B0;
      else if (btn_rise[BTN_B1])    act = ACT_B1;
`endif
    end
  end

  // State register (also holds the registered outputs).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      item_q  <= IT_WELCOME;
      addr_q  <= 8'h00;
      cmd_q   <= CMD_NONE;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next-state and menu-item logic.
  always_comb begin
    state_d = state_q;
    item_d  = item_q;

    // Up/down saturate at the ends of the current state's item list.
    if (act == ACT_UP && item_q > item_lo(state_q))
      item_d = item_q - 6'd1;
    else if (act == ACT_DOWN && item_q < item_hi(state_q))
      item_d = item_q + 6'd1;

    case (state_q)
      ST_STARTUP: begin
        if (init || act == ACT_ENTER) begin
          state_d = ST_IDLE;
          item_d  = IT_WELCOME;
        end
      end
      ST_IDLE: begin
        if (act == ACT_EV_INCOMING) begin
          state_d = ST_INCOMING;
          item_d  = IT_CALLER_ID;
        end else if (act == ACT_RIGHT) begin
          state_d = ST_MENU;
          item_d  = IT_CALL_NUMBER;
        end
      end
      ST_MENU: begin
        if (act == ACT_EV_INCOMING) begin
          state_d = ST_INCOMING;
          item_d  = IT_CALLER_ID;
        end else if (act == ACT_LEFT) begin
          state_d = ST_IDLE;
          item_d  = IT_WELCOME;
        end else if (act == ACT_ENTER && item_q == IT_CALL_NUMBER) begin
          state_d = ST_DIALING;
          item_d  = IT_ENTER_ADDR;
        end
      end
      ST_INCOMING: begin
        if (act == ACT_EV_ENDED || act == ACT_B1 ||
            (act == ACT_ENTER && item_q == IT_REJECT)) begin
          state_d = ST_IDLE;
          item_d  = IT_WELCOME;
        end else if (act == ACT_B0 || (act == ACT_ENTER && item_q == IT_ACCEPT)) begin
          state_d = ST_BUSY;
          item_d  = IT_BUSY_CALLER;
        end
      end
      ST_BUSY: begin
        if (act == ACT_EV_ENDED) begin
          state_d = ST_IDLE;
          item_d  = IT_WELCOME;
        end else if (act == ACT_B1 || (act == ACT_ENTER && item_q == IT_END_CALL)) begin
          state_d = ST_WAIT_END;
          item_d  = IT_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (act == ACT_EV_ENDED) begin
          state_d = ST_IDLE;
          item_d  = IT_WELCOME;
        end
      end
      ST_DIALING: begin
        if (act == ACT_EV_CONNECTED) begin
          state_d = ST_BUSY;
          item_d  = IT_BUSY_CALLER;
        end else if (act == ACT_EV_FAILED) begin
          state_d = ST_IDLE;
          item_d  = IT_WELCOME;
        end else if (act == ACT_ENTER && item_q == IT_ENTER_ADDR) begin
          item_d  = IT_CALLING;
        end else if (act == ACT_LEFT && item_q == IT_ENTER_ADDR) begin
          state_d = ST_MENU;
          item_d  = IT_CALL_NUMBER;
        end else if (act == ACT_LEFT && item_q == IT_CALLING) begin
          state_d = ST_WAIT_END;
          item_d  = IT_WAIT_END;
        end
      end
      default: begin
        state_d = ST_IDLE;
        item_d  = IT_WELCOME;
      end
    endcase
  end

  // Command pulse and address output logic.
  always_comb begin
    cmd_d  = CMD_NONE;
    addr_d = addr_q;

    // While the address-entry item is shown the address tracks the switches,
    // so the DIAL latch below naturally captures the switch value.
    if (item_q == IT_ENTER_ADDR)
      addr_d = sw;

    case (state_q)
      ST_IDLE, ST_MENU: begin
        if (act == ACT_EV_INCOMING)
          addr_d = inc_address;
      end
      ST_INCOMING: begin
        if (act == ACT_B0 || (act == ACT_ENTER && item_q == IT_ACCEPT))
          cmd_d = CMD_ACCEPT;
        else if (act == ACT_B1 || (act == ACT_ENTER && item_q == IT_REJECT))
          cmd_d = CMD_REJECT;
      end
      ST_BUSY: begin
        if (act == ACT_B1 || (act == ACT_ENTER && item_q == IT_END_CALL))
          cmd_d = CMD_END;
      end
      ST_DIALING: begin
        if (act == ACT_ENTER && item_q == IT_ENTER_ADDR)
          cmd_d = CMD_DIAL;
        else if (act == ACT_LEFT && item_q == IT_CALLING)
          cmd_d = CMD_END;
      end
      default: begin
        cmd_d = CMD_NONE;
      end
    endcase
  end

  assign address           = addr_q;
  assign command           = cmd_q;
  assign current_state     = state_q;
  assign current_menu_item = item_q;

endmodule

// File: tb/tb_user_interface.sv
// tb_user_interface: directed self-checking bench for user_interface.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_user_interface;

  localparam int E  = 0;
  localparam int U  = 1;
  localparam int D  = 2;
  localparam int L  = 3;
  localparam int R  = 4;
  localparam int B0 = 5;
  localparam int B1 = 6;
  localparam int B2 = 7;
  localparam int B3 = 8;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic [8:0] btn;
  logic [2:0] inc_command;
  logic       init;
  logic [7:0] inc_address;
  logic [7:0] address;
  logic [2:0] command;
  logic [2:0] current_state;
  logic [5:0] current_menu_item;

  int checks = 0;
  int errors = 0;

  user_interface dut (
    .clk               (clk),
    .reset             (reset),
    .s7                (sw[7]),
    .s6                (sw[6]),
    .s5                (sw[5]),
    .s4                (sw[4]),
    .s3                (sw[3]),
    .s2                (sw[2]),
    .s1                (sw[1]),
    .s0                (sw[0]),
    .b3                (btn[B3]),
    .b2                (btn[B2]),
    .b1                (btn[B1]),
    .b0                (btn[B0]),
    .enter             (btn[E]),
    .up                (btn[U]),
    .down              (btn[D]),
    .left              (btn[L]),
    .right             (btn[R]),
    .inc_command       (inc_command),
    .init              (init),
    .inc_address       (inc_address),
    .address           (address),
    .command           (command),
    .current_state     (current_state),
    .current_menu_item (current_menu_item)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_si(input string tag, input logic [7:0] st, input logic [7:0] it);
    chk({tag, "_state"}, {5'd0, current_state}, st);
    chk({tag, "_item"}, {2'd0, current_menu_item}, it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    tick();
  endtask

  task automatic idle();
    btn = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; sw = 8'h00; btn = '0; inc_command = 3'd0; init = 1'b0; inc_address = 8'h00;
    #12;
    chk_si("rst", 8'd0, 8'd0);
    chk("rst_cmd", {5'd0, command}, 8'd0);
    chk("rst_addr", address, 8'h00);
    @(negedge clk); reset = 1'b0;
    tick();
    chk_si("startup_hold", 8'd0, 8'd0);

    press(E); chk_si("enter_idle", 8'd1, 8'd0); idle();
    press(R); chk_si("right_menu", 8'd2, 8'd1); idle();
    press(L); chk_si("left_idle", 8'd1, 8'd0); idle();

    // Incoming call, rejected; the held event code must not re-trigger.
    inc_address = 8'h3C; inc_command = 3'd5; tick();
    chk_si("inc1", 8'd3, 8'd8);
    chk("inc1_addr", address, 8'h3C);
    press(D); chk_si("inc_d1", 8'd3, 8'd9); idle();
    press(D); chk_si("inc_d2", 8'd3, 8'd10); idle();
    press(D); chk_si("inc_dsat", 8'd3, 8'd10); idle();
    press(E); chk("rej_cmd", {5'd0, command}, 8'd3); chk_si("rej", 8'd1, 8'd0);
    idle(); chk("rej_cmd_clr", {5'd0, command}, 8'd0);
    tick(); tick(); chk_si("held_no_retrig", 8'd1, 8'd0);
    inc_command = 3'd0; tick();

    // Incoming call, accepted, ended from BUSY.
    inc_command = 3'd5; tick(); chk_si("inc2", 8'd3, 8'd8);
    btn[D] = 1'b1; tick(); tick(); tick(); chk_si("held_down_once", 8'd3, 8'd9); idle();
    press(U); chk_si("inc_u", 8'd3, 8'd8); idle();
    press(U); chk_si("inc_usat", 8'd3, 8'd8); idle();
    press(D); idle();
    press(E); chk("acc_cmd", {5'd0, command}, 8'd2); chk_si("acc", 8'd4, 8'd16);
    idle(); chk("acc_cmd_clr", {5'd0, command}, 8'd0);
    press(D); chk_si("busy_d", 8'd4, 8'd17); idle();
    press(D); chk_si("busy_dsat", 8'd4, 8'd17); idle();
    press(E); chk("end_cmd", {5'd0, command}, 8'd4); chk_si("end", 8'd5, 8'd18);
    idle(); chk("end_cmd_clr", {5'd0, command}, 8'd0);
    inc_command = 3'd6; tick(); chk_si("ended", 8'd1, 8'd0);
    inc_command = 3'd0; tick();

    // Dial, connected, ended.
    press(R); idle();
    sw = 8'hA5; press(E); chk_si("dialing", 8'd6, 8'd24); idle();
    chk("addr_live1", address, 8'hA5);
    sw = 8'h5A; tick(); chk("addr_live2", address, 8'h5A);
    sw = 8'hA5; press(E);
    chk("dial_cmd", {5'd0, command}, 8'd1); chk("dial_addr", address, 8'hA5);
    chk_si("dial", 8'd6, 8'd25);
    idle(); chk("dial_cmd_clr", {5'd0, command}, 8'd0);
    sw = 8'hFF; tick(); chk("addr_held", address, 8'hA5);
    inc_command = 3'd1; tick(); chk_si("connected", 8'd4, 8'd16);
    inc_command = 3'd6; tick(); chk_si("conn_ended", 8'd1, 8'd0);
    inc_command = 3'd0; tick();

    // Dial, failed.
    press(R); idle(); press(E); idle(); press(E); idle();
    inc_command = 3'd2; tick(); chk_si("failed", 8'd1, 8'd0);
    inc_command = 3'd0; tick();

    // Back out of address entry.
    press(R); idle(); press(E); idle();
    press(L); chk_si("dial_back", 8'd2, 8'd1); idle();

    // Button priority: down beats left in the same cycle.
    btn[L] = 1'b1; btn[D] = 1'b1; tick(); chk_si("prio_btn", 8'd2, 8'd2); idle();
    press(L); chk_si("menu_left", 8'd1, 8'd0); idle();

    // Event beats a simultaneous right press.
    btn[R] = 1'b1; inc_address = 8'h11; inc_command = 3'd5; tick();
    chk_si("prio_ev", 8'd3, 8'd8); chk("prio_ev_addr", address, 8'h11); idle();

    // Quick accept key.
    press(B0);
`ifdef UI_QUICK_KEYS_EN
    chk("quick_cmd", {5'd0, command}, 8'd2); chk_si("quick", 8'd4, 8'd16);
`else
    chk("quick_cmd", {5'd0, command}, 8'd0); chk_si("quick", 8'd3, 8'd8);
`endif
    idle();
    inc_command = 3'd6; tick(); chk_si("quick_ended", 8'd1, 8'd0);
    inc_command = 3'd0; tick();

    // Hang up while calling.
    press(R); idle(); press(E); idle(); press(E); idle();
    press(L); chk("hang_cmd", {5'd0, command}, 8'd4); chk_si("hang", 8'd5, 8'd18); idle();

    // Asynchronous reset mid-call, then init leaves STARTUP.
    reset = 1'b1; #2;
    chk_si("arst", 8'd0, 8'd0);
    chk("arst_cmd", {5'd0, command}, 8'd0);
    chk("arst_addr", address, 8'h00);
    init = 1'b1;
    @(negedge clk); reset = 1'b0;
    tick(); chk_si("init_idle", 8'd1, 8'd0);
    init = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_interface.md
# user_interface

Menu/call-control finite state machine for the FPGA telephone. It turns debounced front-panel buttons and switches into menu navigation and one-cycle commands for the application layer. It also reacts to call events reported by the application layer. Its state and menu-item outputs drive the display and text-rendering logic.

## Interface
- No parameters.
- `clk` in 1: system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `s7`..`s0` in 1 each: switches; `{s7..s0}` is the dial address.
- `b3`..`b0` in 1 each: auxiliary buttons, debounced, active-high.
  - `b0` is quick-accept and `b1` is quick-hangup (see Configuration).
  - `b3` and `b2` are ignored.
- `enter`, `up`, `down`, `left`, `right` in 1 each: debounced navigation buttons, active-high.
- `inc_command` in 3: event code from the application layer, held as a level.
- `init` in 1: application layer is ready.
- `inc_address` in 8: caller address reported with an incoming call.
- `address` out 8: target/peer address for the application and display.
- `command` out 3: one-cycle command pulse. 0 none, 1 DIAL, 2 ACCEPT, 3 REJECT, 4 END.
- `current_state` out 3: FSM state code.
- `current_menu_item` out 6: menu item code for the display.

## Operation
- **Button edges:** every button is registered, and only a rising edge (now 1, previous 0) acts. Holding a button gives one action.
- **Button priority:** when several buttons rise in the same cycle, only one acts, in the order enter > up > down > left > right > b0 > b1.
- **Event decode:** an event fires when `inc_command` differs from its registered previous value and is nonzero.
  - Codes: 1 CONNECTED, 2 FAILED, 5 INCOMING, 6 ENDED.
  - Other codes are ignored.
  - An event has priority over any button in the same cycle.
- **States (`current_state`) and menu items (`current_menu_item`):**
  - 0 STARTUP: item 0 (welcome). `enter` or `init` goes to IDLE.
  - 1 IDLE: item 0 (welcome/date-time).
    - `right` goes to MENU, item 1.
    - INCOMING goes to INCOMING, item 8.
  - 2 MENU: items 1 (call number) and 2 (status).
    - `left` goes to IDLE.
    - `enter` on item 1 goes to DIALING, item 24.
    - INCOMING goes to INCOMING, item 8.
  - 3 INCOMING: items 8 (caller ID), 9 (accept), 10 (reject).
    - `enter` on 9 pulses ACCEPT and goes to BUSY, item 16.
    - `enter` on 10 pulses REJECT and goes to IDLE.
    - ENDED goes to IDLE.
  - 4 BUSY: items 16 (caller ID), 17 (end call).
    - `enter` on 17 pulses END and goes to WAIT_END, item 18.
    - ENDED goes to IDLE.
  - 5 WAIT_END: item 18. ENDED goes to IDLE, item 0.
  - 6 DIALING: items 24 (enter address) and 25 (calling).
    - On 24, `enter` pulses DIAL, latches the address and moves to item 25. `left` goes to MENU, item 1.
    - On 25, `left` pulses END and goes to WAIT_END.
    - CONNECTED goes to BUSY, item 16. FAILED goes to IDLE.
  - 7 is illegal and goes to IDLE on the next clock.
- **Menu navigation:** `up`/`down` move within the current state's item list and saturate at its ends (no wrap).
- **No-action cases:**
  - Buttons with no listed transition do nothing.
  - INCOMING in BUSY, DIALING, WAIT_END or STARTUP is ignored.
- **`address` output:**
  - Follows `{s7..s0}` live on item 24.
  - Latches `{s7..s0}` on DIAL.
  - Latches `inc_address` on an INCOMING event.
  - Otherwise it holds its value.

## Timing
- All outputs are registered.
- A qualifying edge or event sampled at clock edge N updates state, item, `address` and `command` at edge N.
- `command` is nonzero for exactly one cycle and returns to 0.
- Reset values:
  - `current_state` = 0 and `current_menu_item` = 0.
  - `command` = 0 and `address` = 0.
  - Button history = 0.
  - Previous `inc_command` = 0.
- Asserting reset mid-call aborts the call. No END command is issued.

## Configuration
- Macro: `UI_QUICK_KEYS_EN`.
- **Defined:**
  - `b0` rising in INCOMING acts as ACCEPT (pulse 2, go to BUSY).
  - `b1` rising in INCOMING acts as REJECT.
  - `b1` rising in BUSY acts as END (pulse 4, go to WAIT_END).
- **Undefined:** `b0` and `b1` are ignored.

## Structure
- Shared package `ui_pkg` holds:
  - the state codes;
  - the menu-item codes;
  - the command codes (outbound) and event codes (inbound).
- One sub-module, `ui_edge_detect`: registered rising-edge detector, used for each button and for `inc_command` change detection.

## Test plan
- Reset, then `enter` pulse: state goes 0 to 1, item 0.
- `right` gives state 2, item 1. `left` gives state 1, item 0.
- From IDLE, `inc_command`=5 with `inc_address`=8'h3C:
  - state 3, item 8, `address`=8'h3C;
  - `down` gives item 9;
  - `enter` gives a one-cycle `command`=2, state 4, item 16.
- In BUSY:
  - `down` gives item 17;
  - `enter` gives `command`=4 pulse, state 5, item 18;
  - `inc_command`=6 gives state 1, item 0;
  - a held `inc_command`=5 does not re-trigger.
- Dial flow:
  - MENU item 1 with switches=8'hA5: `enter` gives state 6, item 24;
  - `enter` gives `command`=1, `address`=8'hA5, item 25;
  - `inc_command`=1 gives state 4;
  - repeating with `inc_command`=2 instead gives state 1.
- With `UI_QUICK_KEYS_EN` defined, `b0` in INCOMING gives `command`=2 and state 4. Undefined, nothing happens.
